// File: rtl/receptor_serial_8n1_pkg.sv
// ============================================================================
//  serial_pkg
//  Shared definitions for the 8N1 receiver and the serial-command interpreter.
//  Rev 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

  localparam int SERIAL_DATA_W = 8;

  // Bit the interpreter decodes as the control-frame flag.
  localparam int CTRL_FLAG_BIT = 7;

  typedef enum logic [2:0] {
    ESPERA_LINHA = 3'd0,
    OCIOSO       = 3'd1,
    INICIO       = 3'd2,
    DADOS        = 3'd3,
    PARADA       = 3'd4
  } estado_rx_t;

endpackage

`default_nettype wire

// File: rtl/receptor_serial_8n1_if.sv
// ============================================================================
//  receptor_serial_8n1_if
//  Serial line input and received-byte outputs of the 8N1 receiver.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface receptor_serial_8n1_if;

  logic                                 rx_serial;
  logic [serial_pkg::SERIAL_DATA_W-1:0] dados_serial_recebido;
  logic [serial_pkg::SERIAL_DATA_W-1:0] ultimo_dado;
  logic                                 pronto;
  logic                                 erro_frame;
  logic                                 ocupado;

  modport master (
    input  rx_serial,
    output dados_serial_recebido,
    output ultimo_dado,
    output pronto,
    output erro_frame,
    output ocupado
  );

  modport slave (
    output rx_serial,
    input  dados_serial_recebido,
    input  ultimo_dado,
    input  pronto,
    input  erro_frame,
    input  ocupado
  );

endinterface

`default_nettype wire

// File: rtl/receptor_serial_8n1_sincronizador_2ff.sv
// ============================================================================
//  sincronizador_2ff
//  Two-flop synchronizer for a single asynchronous bit, configurable reset value.
//  Rev 1.0
// ============================================================================
`default_nettype none

module sincronizador_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic d,
  output logic      q
);

  logic [1:0] r_ff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ff <= {2{RESET_VALUE}};
    end else begin
      r_ff <= {r_ff[0], d};
    end
  end

  assign q = r_ff[1];

endmodule

`default_nettype wire

// File: rtl/receptor_serial_8n1.sv
// ============================================================================
//  receptor_serial_8n1
//  UART receiver, 8N1, LSB first; one-cycle pulse per good byte or framing error.
//  Rev 1.0
// ============================================================================
`default_nettype none

module receptor_serial_8n1
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  wire logic               clock,
  input  wire logic               reset,
  receptor_serial_8n1_if.master   bus
);

  localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int                HALF_BIT   = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0]  CNT_FIM    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MEIO   = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0]  CNT_UM     = CNT_W'(1);
  // Synchronizer outputs reset-value 1s for two clocks after reset release, so
  // the line must read high for three consecutive clocks before re-arming.
  localparam logic [CNT_W-1:0]  CNT_ARME   = CNT_W'(2);
  localparam logic [2:0]        IDX_ULTIMO = 3'(SERIAL_DATA_W - 1);

  logic                      w_rx_s;
  estado_rx_t                r_estado;
  logic [CNT_W-1:0]          r_cnt_tick;
  logic [2:0]                r_idx_bit;
  logic [SERIAL_DATA_W-1:0]  r_shift;
  logic [SERIAL_DATA_W-1:0]  r_dados;
  logic [SERIAL_DATA_W-1:0]  r_ultimo;
  logic                      r_pronto;
  logic                      r_erro;
  logic                      r_ocupado;

  sincronizador_2ff #(
    .RESET_VALUE (1'b1)
  ) u_sinc_rx (
    .clock (clock),
    .reset (reset),
    .d     (bus.rx_serial),
    .q     (w_rx_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= ESPERA_LINHA;
      r_cnt_tick <= '0;
      r_idx_bit  <= '0;
      r_shift    <= '0;
      r_dados    <= '0;
      r_ultimo   <= '0;
      r_pronto   <= 1'b0;
      r_erro     <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_pronto  <= 1'b0;
      r_erro    <= 1'b0;
      r_dados   <= '0;
      r_ocupado <= 1'b1;

      case (r_estado)
        ESPERA_LINHA: begin
          if (!w_rx_s) begin
            r_cnt_tick <= '0;
          end else if (r_cnt_tick == CNT_ARME) begin
            r_estado   <= OCIOSO;
            r_cnt_tick <= '0;
            r_ocupado  <= 1'b0;
          end else begin
            r_cnt_tick <= r_cnt_tick + CNT_UM;
          end
        end

        OCIOSO: begin
          if (!w_rx_s) begin
            r_estado   <= INICIO;
            r_cnt_tick <= '0;
          end else begin
            r_ocupado  <= 1'b0;
          end
        end

        INICIO: begin
          if (r_cnt_tick == CNT_MEIO) begin
            r_cnt_tick <= '0;
            if (!w_rx_s) begin
              r_estado  <= DADOS;
              r_idx_bit <= '0;
            end else begin
              r_estado  <= OCIOSO;
              r_ocupado <= 1'b0;
            end
          end else begin
            r_cnt_tick <= r_cnt_tick + CNT_UM;
          end
        end

        DADOS: begin
          if (r_cnt_tick == CNT_FIM) begin
            r_shift[r_idx_bit] <= w_rx_s;
            r_cnt_tick         <= '0;
            r_idx_bit          <= r_idx_bit + 3'd1;
            if (r_idx_bit == IDX_ULTIMO) begin
              r_estado <= PARADA;
            end
          end else begin
            r_cnt_tick <= r_cnt_tick + CNT_UM;
          end
        end

        PARADA: begin
          if (r_cnt_tick == CNT_FIM) begin
            r_cnt_tick <= '0;
            if (w_rx_s) begin
              // Leaving mid-stop-bit lets a start bit with zero idle be caught.
              r_dados   <= r_shift;
              r_ultimo  <= r_shift;
              r_pronto  <= 1'b1;
              r_estado  <= OCIOSO;
              r_ocupado <= 1'b0;
            end else begin
              r_erro    <= 1'b1;
              r_estado  <= ESPERA_LINHA;
            end
          end else begin
            r_cnt_tick <= r_cnt_tick + CNT_UM;
          end
        end

        default: begin
          r_estado   <= ESPERA_LINHA;
          r_cnt_tick <= '0;
        end
      endcase
    end
  end

  assign bus.dados_serial_recebido = r_dados;
  assign bus.ultimo_dado           = r_ultimo;
  assign bus.pronto                = r_pronto;
  assign bus.erro_frame            = r_erro;
  assign bus.ocupado               = r_ocupado;

endmodule

`default_nettype wire

// File: tb/tb_receptor_serial_8n1.sv
// ============================================================================
//  tb_receptor_serial_8n1
//  Self-checking bench: frame table with scoreboard plus hand-written corner cases.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_receptor_serial_8n1;

  localparam int CPB = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  receptor_serial_8n1_if bus_if ();

  receptor_serial_8n1 #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int n_vec       = 0;
  int n_err       = 0;
  int n_pronto    = 0;
  int n_erro_seen = 0;
  int exp_pronto  = 0;
  int exp_erro    = 0;
  int cyc         = 0;
  int last_cyc    = 0;
  int gap         = 0;
  logic [7:0] sb_q [$];
  logic [7:0] last_good  = 8'h00;
  logic       prev_pronto = 1'b0;
  logic       prev_erro   = 1'b0;

  typedef struct {
    logic [7:0] dado;
    logic       stop;
    int         idle_bits;
    logic       chk_gap;
  } vec_t;

  vec_t tab [7];

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, got, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Scoreboard side: every pronto pops one expected byte.
  always @(negedge clock) begin
    logic [7:0] exp_b;
    if (prev_pronto) begin
      check("pronto_width", 32'(bus_if.pronto), 32'd0);
      check("dados_after_pronto", 32'(bus_if.dados_serial_recebido), 32'd0);
    end
    if (prev_erro) check("erro_width", 32'(bus_if.erro_frame), 32'd0);
    if (bus_if.pronto) begin
      n_pronto++;
      gap      = cyc - last_cyc;
      last_cyc = cyc;
      check("pronto_erro_excl", 32'(bus_if.erro_frame), 32'd0);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pronto: got byte 0x%0h, expected no pronto",
                 bus_if.dados_serial_recebido);
      end else begin
        exp_b = sb_q.pop_front();
        check("dados", 32'(bus_if.dados_serial_recebido), 32'(exp_b));
        check("ultimo_at_pronto", 32'(bus_if.ultimo_dado), 32'(exp_b));
      end
    end
    if (bus_if.erro_frame) n_erro_seen++;
    prev_pronto = bus_if.pronto;
    prev_erro   = bus_if.erro_frame;
  end

  task automatic send_bit(input logic v);
    bus_if.rx_serial = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic idle_line(input int n);
    bus_if.rx_serial = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    if (stop_v) begin
      sb_q.push_back(b);
      exp_pronto++;
      last_good = b;
    end else begin
      exp_erro++;
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_v);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pronto_cnt"}, 32'(n_pronto), 32'(exp_pronto));
    check({tag, "_erro_cnt"},   32'(n_erro_seen), 32'(exp_erro));
    check({tag, "_ultimo"},     32'(bus_if.ultimo_dado), 32'(last_good));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dados"},   32'(bus_if.dados_serial_recebido), 32'd0);
    check({tag, "_ultimo"},  32'(bus_if.ultimo_dado), 32'd0);
    check({tag, "_pronto"},  32'(bus_if.pronto), 32'd0);
    check({tag, "_erro"},    32'(bus_if.erro_frame), 32'd0);
    check({tag, "_ocupado"}, 32'(bus_if.ocupado), 32'd0);
  endtask

  initial begin
    tab[0] = '{8'h85, 1'b1, 2, 1'b0};
    tab[1] = '{8'h00, 1'b1, 1, 1'b0};
    tab[2] = '{8'hFF, 1'b1, 1, 1'b0};
    tab[3] = '{8'hA5, 1'b1, 1, 1'b0};
    tab[4] = '{8'h81, 1'b1, 0, 1'b0};
    tab[5] = '{8'h10, 1'b1, 1, 1'b1};
    tab[6] = '{8'h7E, 1'b1, 1, 1'b0};

    bus_if.rx_serial = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    idle_line(2 * CPB);
    check("idle_ocupado", 32'(bus_if.ocupado), 32'd0);

    // Table of frames; back-to-back entries have idle_bits = 0.
    for (int i = 0; i < 7; i++) begin
      send_frame(tab[i].dado, tab[i].stop);
      check_counts("tab");
      if (tab[i].chk_gap) check("b2b_gap", 32'(gap), 32'(10 * CPB));
      if (tab[i].idle_bits > 0) begin
        idle_line(tab[i].idle_bits * CPB);
        check("tab_ocupado", 32'(bus_if.ocupado), 32'd0);
      end
    end

    // Short low glitch rejected at the start-bit midpoint.
    bus_if.rx_serial = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    idle_line(12);
    check("glitch_ocupado", 32'(bus_if.ocupado), 32'd0);
    check_counts("glitch");

    // Framing error, then line held low: receiver must wait for a high line.
    send_frame(8'h91, 1'b0);
    bus_if.rx_serial = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    check("break_ocupado", 32'(bus_if.ocupado), 32'd1);
    check_counts("ferr");
    idle_line(2 * CPB);
    check("rearm_ocupado", 32'(bus_if.ocupado), 32'd0);
    send_frame(8'h81, 1'b1);
    check_counts("after_ferr");
    idle_line(CPB);

    // Reset in the middle of data bit 4 of 0xF0.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    bus_if.rx_serial = 1'b1;
    repeat (8) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    last_good = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    idle_line(5 * CPB);
    check_counts("midreset");
    send_frame(8'h55, 1'b1);
    check_counts("after_reset");
    idle_line(CPB);

    // Line low across reset release.
    bus_if.rx_serial = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    last_good = 8'h00;
    repeat (300) @(posedge clock);
    #1;
    check("lowrst_ocupado", 32'(bus_if.ocupado), 32'd1);
    check_counts("lowrst");
    idle_line(10);
    check("lowrst_release_ocupado", 32'(bus_if.ocupado), 32'd0);
    send_frame(8'h3C, 1'b1);
    check_counts("final");
    idle_line(CPB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
